// File: rtl/slot_seq_reader.sv
// Frame sequencer: sweeps a frame counter into the slot-to-address mapper and
// captures one synchronous ROM word per slot, with a start/busy/done handshake.
module slot_seq_reader #(
  parameter int SLOT_LEN  = 13,
  parameter int NUM_SLOTS = 16,
  parameter int DATA_W    = 8,
  parameter int CAP_OFS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [9:0]        count,
  output logic [3:0]        slot_idx,
  output logic              slot_first,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start, counters held at 0
  // RUN   | sweeping count/sub/slot_idx, capturing at sub == CAP_OFS
  // FIN   | one-cycle done strobe, always returns to IDLE
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [9:0] LAST_CNT = 10'(SLOT_LEN * NUM_SLOTS - 1);
  localparam logic [5:0] SUB_LAST = 6'(SLOT_LEN - 1);
  localparam logic [5:0] SUB_CAP  = 6'(CAP_OFS);

  state_t     state;
  logic [5:0] sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sub        <= '0;
      count      <= '0;
      slot_idx   <= '0;
      slot_first <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      done       <= 1'b0;
      slot_first <= 1'b0;
      case (state)
        IDLE: begin
          count    <= '0;
          sub      <= '0;
          slot_idx <= '0;
          busy     <= 1'b0;
          if (start && !abort) begin
            state      <= RUN;
            busy       <= 1'b1;
            slot_first <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            // an abort also cancels a capture due on this same edge
            state    <= IDLE;
            count    <= '0;
            sub      <= '0;
            slot_idx <= '0;
            busy     <= 1'b0;
          end else begin
            if (sub == SUB_CAP) begin
              data_out   <= rom_data;
              data_valid <= 1'b1;
            end
            if (count == LAST_CNT) begin
              state    <= FIN;
              busy     <= 1'b0;
              done     <= 1'b1;
              count    <= '0;
              sub      <= '0;
              slot_idx <= '0;
            end else begin
              count <= count + 10'd1;
              if (sub == SUB_LAST) begin
                sub        <= '0;
                slot_idx   <= slot_idx + 4'd1;
                slot_first <= 1'b1;
              end else begin
                sub <= sub + 6'd1;
              end
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_seq_reader.sv
// Scoreboard bench for slot_seq_reader: default instance with mapper + ROM model,
// plus a small SLOT_LEN=4 / NUM_SLOTS=3 instance.
module tb_slot_seq_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, abort_a, start_b, abort_b;
  logic [9:0] count_a, count_b;
  logic [3:0] slot_idx_a, slot_idx_b;
  logic       slot_first_a, slot_first_b;
  logic [7:0] rom_data_a, rom_data_b, data_out_a, data_out_b;
  logic       data_valid_a, data_valid_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] addr_a, addr_b;

  slot_seq_reader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .count(count_a), .slot_idx(slot_idx_a), .slot_first(slot_first_a),
    .rom_data(rom_data_a), .data_out(data_out_a), .data_valid(data_valid_a),
    .busy(busy_a), .done(done_a)
  );

  slot_seq_reader #(.SLOT_LEN(4), .NUM_SLOTS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .count(count_b), .slot_idx(slot_idx_b), .slot_first(slot_first_b),
    .rom_data(rom_data_b), .data_out(data_out_b), .data_valid(data_valid_b),
    .busy(busy_b), .done(done_b)
  );

  // slot 15 maps to address 2; out-of-range counts map to 0
  function automatic logic [3:0] map_a(input logic [9:0] c);
    int s;
    s = int'(c) / 13;
    if (c >= 10'd208) return 4'd0;
    if (s == 15) return 4'd2;
    return 4'(s);
  endfunction

  always @(posedge clk) begin
    addr_a     <= map_a(count_a);
    rom_data_a <= 8'h10 + {4'h0, addr_a};
    addr_b     <= 4'(count_b / 10'd4);
    rom_data_b <= 8'h40 + {4'h0, addr_b};
  end

  typedef struct packed {
    logic [9:0] cnt;
    logic [7:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [9:0] prev_a = '0;
  logic [9:0] prev_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid_a) begin
        if (q_a.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL strobe_a: unexpected strobe at count %0d", count_a);
        end else begin
          ea = q_a.pop_front();
          chk("strobe_count_a", 32'(count_a), 32'(ea.cnt));
          chk("data_a", 32'(data_out_a), 32'(ea.data));
        end
      end
      if (busy_a) begin
        chk("slot_first_a", 32'(slot_first_a), 32'(count_a % 10'd13 == 10'd0));
        chk("slot_idx_a", 32'(slot_idx_a), 32'(count_a / 10'd13));
      end
      if (done_a) begin
        done_cnt_a++;
        chk("done_prev_count_a", 32'(prev_a), 32'd207);
        chk("done_busy_a", 32'(busy_a), 32'd0);
      end
      prev_a = count_a;

      if (data_valid_b) begin
        if (q_b.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL strobe_b: unexpected strobe at count %0d", count_b);
        end else begin
          eb = q_b.pop_front();
          chk("strobe_count_b", 32'(count_b), 32'(eb.cnt));
          chk("data_b", 32'(data_out_b), 32'(eb.data));
        end
      end
      if (busy_b) begin
        chk("slot_first_b", 32'(slot_first_b), 32'(count_b % 10'd4 == 10'd0));
        chk("slot_idx_b", 32'(slot_idx_b), 32'(count_b / 10'd4));
      end
      if (done_b) begin
        done_cnt_b++;
        chk("done_prev_count_b", 32'(prev_b), 32'd11);
      end
      prev_b = count_b;
    end
  end

  // Caller sits in the first RUN cycle; returns in the FIN cycle.
  task automatic run_frame(input bit sel, input string nm, input int len);
    int n;
    logic [9:0] last;
    n = 0;
    last = '0;
    while ((sel ? busy_b : busy_a) && n < 2000) begin
      n++;
      last = sel ? count_b : count_a;
      step();
    end
    chk({nm, "_run_cycles"}, 32'(n), 32'(len));
    chk({nm, "_last_count"}, 32'(last), 32'(len - 1));
    chk({nm, "_done"}, 32'(sel ? done_b : done_a), 32'd1);
    chk({nm, "_fin_count"}, 32'(sel ? count_b : count_a), 32'd0);
  endtask

  task automatic wait_count_a(input logic [9:0] v);
    int n;
    n = 0;
    while (count_a != v && n < 1000) begin
      n++;
      step();
    end
    chk("wait_count_a", 32'(count_a), 32'(v));
  endtask

  task automatic push_a(input int first, input int last_k);
    exp_t e;
    for (int k = first; k <= last_k; k++) begin
      e.cnt  = 10'(13 * k + 3);
      e.data = (k == 15) ? 8'h12 : 8'(8'h10 + k);
      q_a.push_back(e);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic chk_zero_a(input string nm);
    chk({nm, "_count"}, 32'(count_a), 32'd0);
    chk({nm, "_slot_idx"}, 32'(slot_idx_a), 32'd0);
    chk({nm, "_slot_first"}, 32'(slot_first_a), 32'd0);
    chk({nm, "_data_out"}, 32'(data_out_a), 32'd0);
    chk({nm, "_data_valid"}, 32'(data_valid_a), 32'd0);
    chk({nm, "_busy"}, 32'(busy_a), 32'd0);
    chk({nm, "_done"}, 32'(done_a), 32'd0);
  endtask

  int   gap;
  exp_t eb0;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    step(3);
    chk_zero_a("reset");
    chk("reset_busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", 32'(busy_a), 32'd0);

    // single frame
    push_a(0, 15);
    pulse_start_a();
    chk("first_run_count", 32'(count_a), 32'd0);
    chk("first_run_busy", 32'(busy_a), 32'd1);
    chk("first_run_slot_first", 32'(slot_first_a), 32'd1);
    run_frame(1'b0, "frame1", 208);
    step();

    // start held high: two back-to-back frames, 2-cycle gap
    push_a(0, 15);
    push_a(0, 15);
    start_a = 1'b1;
    step();
    run_frame(1'b0, "cont1", 208);
    gap = 0;
    while (!busy_a && gap < 10) begin
      gap++;
      step();
    end
    chk("restart_gap", 32'(gap), 32'd2);
    chk("restart_count", 32'(count_a), 32'd0);
    start_a = 1'b0;
    run_frame(1'b0, "cont2", 208);
    step(2);
    chk("no_third_frame", 32'(busy_a), 32'd0);

    // abort at count 55 (slot 4 strobe already visible)
    push_a(0, 4);
    pulse_start_a();
    wait_count_a(10'd55);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort55_busy", 32'(busy_a), 32'd0);
    chk("abort55_count", 32'(count_a), 32'd0);
    chk("abort55_done", 32'(done_a), 32'd0);
    step();
    chk("abort55_done_later", 32'(done_a), 32'd0);

    // abort on the capture cycle of slot 2
    push_a(0, 1);
    pulse_start_a();
    wait_count_a(10'd28);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("abort28_valid", 32'(data_valid_a), 32'd0);
    chk("abort28_data", 32'(data_out_a), 32'h11);
    step(3);
    chk("abort28_data_held", 32'(data_out_a), 32'h11);

    // asynchronous reset mid-frame
    push_a(0, 7);
    pulse_start_a();
    wait_count_a(10'd100);
    #2 rst_n = 1'b0;
    #1 chk_zero_a("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3);
    chk("post_reset_busy", 32'(busy_a), 32'd0);
    chk("post_reset_count", 32'(count_a), 32'd0);

    // small configuration
    for (int k = 0; k < 3; k++) begin
      eb0.cnt  = 10'(4 * k + 3);
      eb0.data = 8'(8'h40 + k);
      q_b.push_back(eb0);
    end
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_first_count", 32'(count_b), 32'd0);
    chk("b_first_busy", 32'(busy_b), 32'd1);
    run_frame(1'b1, "frame_b", 12);
    step(3);

    chk("queue_a_empty", 32'(q_a.size()), 32'd0);
    chk("queue_b_empty", 32'(q_b.size()), 32'd0);
    chk("done_count_a", 32'(done_cnt_a), 32'd3);
    chk("done_count_b", 32'(done_cnt_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
